// File: rtl/timer_mc.sv
// ---------------------------------------------------------------------------
// timer_mc : multi-channel general purpose timer with a shared prescaler.
//
// Optional feature macro: TIMER_MC_PWM_EN
//   When defined, adds a registered pwm output per channel and the CR.pwm_pol
//   bit [4]. When undefined, there is no pwm port and CR[4] reads as 0.
//
// Parameters
//   N_CH   number of timer channels (1..8)
//   CNT_W  counter / compare width (8..32)
//   PSC_W  shared prescaler width (1..16)
//
// Ports
//   clk     single clock, rising edge
//   rst_n   synchronous active-low reset
//   req     bus access request, one cycle per access
//   we      write enable qualifying req
//   addr    byte offset: channel c at 0x10*c (CR/SR/CNTR/CMPR), PSC at 0x100
//   wdata   write data
//   rvalid  read data valid, one cycle after a read request
//   rdata   read data, zero whenever rvalid is low
//   irq     per-channel interrupt level (mtch & irq_en)
//   pwm     per-channel pwm output (TIMER_MC_PWM_EN only)
// ---------------------------------------------------------------------------
module timer_mc #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            we,
  input  logic [11:0]     addr,
  input  logic [31:0]     wdata,
  output logic            rvalid,
  output logic [31:0]     rdata,
  output logic [N_CH-1:0] irq
`ifdef TIMER_MC_PWM_EN
  ,
  output logic [N_CH-1:0] pwm
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Bus decode
  logic       wr_en;
  logic       rd_en;
  logic       ch_space;
  logic       psc_sel;
  logic [3:0] ch_idx;
  logic [1:0] reg_sel;

  assign wr_en    = req & we;
  assign rd_en    = req & ~we;
  assign ch_space = (addr[11:8] == 4'h0) && (addr[1:0] == 2'b00);
  assign ch_idx   = addr[7:4];
  assign reg_sel  = addr[3:2];
  assign psc_sel  = (addr == 12'h100);

  // Shared prescaler
  logic [PSC_W-1:0] psc_reg, psc_next;
  logic [PSC_W-1:0] pcnt_reg, pcnt_next;
  logic             any_act;
  logic             tick;
  logic [N_CH-1:0]  act_vec;
  logic [N_CH-1:0]  ch_hit;
  logic [31:0]      ch_rdata [N_CH];

  assign any_act = |act_vec;
  // ">=" makes a PSC lowered below the running phase tick at once instead
  // of letting the phase run all the way round the counter width.
  assign tick    = any_act && (pcnt_reg >= psc_reg);

  always_comb begin
    psc_next = psc_reg;
    if (wr_en && psc_sel) psc_next = wdata[PSC_W-1:0];
    // Phase restarts from 0 whenever no channel is running.
    if (!any_act || tick) pcnt_next = '0;
    else                  pcnt_next = pcnt_reg + PSC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psc_reg  <= '0;
      pcnt_reg <= '0;
    end else begin
      psc_reg  <= psc_next;
      pcnt_reg <= pcnt_next;
    end
  end

  // Channels
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      state_t           state_reg, state_next;
      logic [CNT_W-1:0] cntr_reg, cntr_next;
      logic [CNT_W-1:0] cmpr_reg, cmpr_next;
      logic             sngl_reg, sngl_next;
      logic             ien_reg, ien_next;
      logic             mtch_reg, mtch_next;
      logic             irq_reg, irq_next;
      logic             hw_set;
      logic             pol_bit;
      logic             sel, cr_wr, sr_wr, cntr_wr, cmpr_wr;
      logic [31:0]      rword;

      assign sel     = ch_space && (ch_idx == 4'(gi));
      assign cr_wr   = wr_en && sel && (reg_sel == 2'd0);
      assign sr_wr   = wr_en && sel && (reg_sel == 2'd1);
      assign cntr_wr = wr_en && sel && (reg_sel == 2'd2);
      assign cmpr_wr = wr_en && sel && (reg_sel == 2'd3);

      always_comb begin
        state_next = state_reg;
        cntr_next  = cntr_reg;
        cmpr_next  = cmpr_reg;
        sngl_next  = sngl_reg;
        ien_next   = ien_reg;
        hw_set     = 1'b0;
        if (state_reg == RUN && tick) begin
          if (cntr_reg == cmpr_reg) begin
            hw_set = 1'b1;
            if (sngl_reg) state_next = IDLE;
            else          cntr_next  = '0;
          end else begin
            // Above CMPR this simply wraps through 0 without a match.
            cntr_next = cntr_reg + CNT_W'(1);
          end
        end
        // A hardware match beats a same-cycle write-1-to-clear.
        mtch_next = hw_set | (mtch_reg & ~(sr_wr & wdata[0]));
        if (cmpr_wr) cmpr_next = wdata[CNT_W-1:0];
        // A bus write replaces whatever the tick would have produced.
        if (cntr_wr) cntr_next = wdata[CNT_W-1:0];
        if (cr_wr) begin
          sngl_next = wdata[2];
          ien_next  = wdata[3];
          if (wdata[0] && state_reg == IDLE) state_next = RUN;
          // hlt applied last so it wins over a simultaneous trg.
          if (wdata[1]) begin
            state_next = IDLE;
            cntr_next  = '0;
          end
        end
        irq_next = mtch_next & ien_next;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg <= IDLE;
          cntr_reg  <= '0;
          cmpr_reg  <= '0;
          sngl_reg  <= 1'b0;
          ien_reg   <= 1'b0;
          mtch_reg  <= 1'b0;
          irq_reg   <= 1'b0;
        end else begin
          state_reg <= state_next;
          cntr_reg  <= cntr_next;
          cmpr_reg  <= cmpr_next;
          sngl_reg  <= sngl_next;
          ien_reg   <= ien_next;
          mtch_reg  <= mtch_next;
          irq_reg   <= irq_next;
        end
      end

`ifdef TIMER_MC_PWM_EN
      logic pol_reg, pol_next;
      logic pwm_reg, pwm_next;

      // Built from next-state values so pwm lines up with the CNTR register.
      always_comb begin
        pol_next = cr_wr ? wdata[4] : pol_reg;
        pwm_next = (state_next == RUN) & ((cntr_next < cmpr_next) ^ pol_next);
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pol_reg <= 1'b0;
          pwm_reg <= 1'b0;
        end else begin
          pol_reg <= pol_next;
          pwm_reg <= pwm_next;
        end
      end

      assign pwm[gi] = pwm_reg;
      assign pol_bit = pol_reg;
`else
      assign pol_bit = 1'b0;
`endif

      always_comb begin
        rword = '0;
        case (reg_sel)
          2'd0: begin
            rword[4] = pol_bit;
            rword[3] = ien_reg;
            rword[2] = sngl_reg;
          end
          2'd1: begin
            rword[1] = (state_reg == RUN);
            rword[0] = mtch_reg;
          end
          2'd2:    rword[CNT_W-1:0] = cntr_reg;
          default: rword[CNT_W-1:0] = cmpr_reg;
        endcase
      end

      assign act_vec[gi]  = (state_reg == RUN);
      assign ch_hit[gi]   = sel;
      assign ch_rdata[gi] = rword;
      assign irq[gi]      = irq_reg;
    end
  endgenerate

  // Read path: one registered cycle, zero when not valid
  logic [31:0] rd_mux;
  logic        rvalid_reg;
  logic [31:0] rdata_reg;

  always_comb begin
    rd_mux = '0;
    if (psc_sel) rd_mux[PSC_W-1:0] = psc_reg;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_hit[i]) rd_mux = ch_rdata[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      rvalid_reg <= rd_en;
      rdata_reg  <= rd_en ? rd_mux : 32'd0;
    end
  end

  assign rvalid = rvalid_reg;
  assign rdata  = rdata_reg;

  // Upper wdata bits are meaningless for narrow registers.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

endmodule

// File: tb/tb_timer_mc.sv
// ---------------------------------------------------------------------------
// tb_timer_mc : self-checking bench for timer_mc.
// A driver issues one bus cycle per clock and steps a behavioural model of
// the timer; the expected bus/irq response of that clock is queued. A monitor
// pops one entry per clock and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_timer_mc;
  localparam int N_CH  = 2;
  localparam int CNT_W = 32;
  localparam int PSC_W = 16;
  localparam longint unsigned CMASK = (64'd1 << CNT_W) - 1;
  localparam longint unsigned PMASK = (64'd1 << PSC_W) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req = 1'b0;
  logic            we = 1'b0;
  logic [11:0]     addr = '0;
  logic [31:0]     wdata = '0;
  logic            rvalid;
  logic [31:0]     rdata;
  logic [N_CH-1:0] irq;
`ifdef TIMER_MC_PWM_EN
  logic [N_CH-1:0] pwm;
`endif

  timer_mc #(.N_CH(N_CH), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .rvalid(rvalid), .rdata(rdata), .irq(irq)
`ifdef TIMER_MC_PWM_EN
    , .pwm(pwm)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  bit              m_run  [N_CH];
  longint unsigned m_cnt  [N_CH];
  longint unsigned m_cmp  [N_CH];
  bit              m_sngl [N_CH];
  bit              m_ien  [N_CH];
  bit              m_pol  [N_CH];
  bit              m_mtch [N_CH];
  longint unsigned m_psc = 0;
  longint unsigned m_phase = 0;

  function automatic logic [31:0] m_read(logic [11:0] a);
    int ch;
    int off;
    bit polv;
    if (a == 12'h100) return 32'(m_psc);
    if (a >= 12'h100 || a % 4 != 0) return 32'd0;
    ch = a / 16;
    off = a % 16;
    if (ch >= N_CH) return 32'd0;
    polv = 1'b0;
`ifdef TIMER_MC_PWM_EN
    polv = m_pol[ch];
`endif
    case (off)
      0:       return {27'd0, polv, m_ien[ch], m_sngl[ch], 2'b00};
      4:       return {30'd0, m_run[ch], m_mtch[ch]};
      8:       return 32'(m_cnt[ch]);
      default: return 32'(m_cmp[ch]);
    endcase
  endfunction

  // Advance the model across one clock edge with the given bus inputs.
  task automatic m_edge(bit r, bit rq, bit w, logic [11:0] a, logic [31:0] d);
    bit any;
    bit tick;
    bit was_run [N_CH];
    bit set_now [N_CH];
    int ch;
    if (!r) begin
      for (int i = 0; i < N_CH; i++) begin
        m_run[i] = 0; m_cnt[i] = 0; m_cmp[i] = 0; m_sngl[i] = 0;
        m_ien[i] = 0; m_pol[i] = 0; m_mtch[i] = 0;
      end
      m_psc = 0;
      m_phase = 0;
      return;
    end
    any = 0;
    for (int i = 0; i < N_CH; i++) any |= m_run[i];
    tick = any && (m_phase == m_psc);
    m_phase = (!any || tick) ? 0 : m_phase + 1;
    for (int i = 0; i < N_CH; i++) begin
      was_run[i] = m_run[i];
      set_now[i] = 0;
      if (m_run[i] && tick) begin
        if (m_cnt[i] == m_cmp[i]) begin
          set_now[i] = 1;
          m_mtch[i] = 1;
          if (m_sngl[i]) m_run[i] = 0;
          else m_cnt[i] = 0;
        end else begin
          m_cnt[i] = (m_cnt[i] + 1) & CMASK;
        end
      end
    end
    if (rq && w) begin
      if (a == 12'h100) m_psc = longint'(d) & PMASK;
      else if (a < 12'h100 && a % 4 == 0 && a / 16 < N_CH) begin
        ch = a / 16;
        case (a % 16)
          0: begin
            m_sngl[ch] = d[2];
            m_ien[ch]  = d[3];
            m_pol[ch]  = d[4];
            if (d[0] && !was_run[ch]) m_run[ch] = 1;
            if (d[1]) begin m_run[ch] = 0; m_cnt[ch] = 0; end
          end
          4: if (d[0] && !set_now[ch]) m_mtch[ch] = 0;
          8: m_cnt[ch] = longint'(d) & CMASK;
          default: m_cmp[ch] = longint'(d) & CMASK;
        endcase
      end
    end
  endtask

  function automatic logic [N_CH-1:0] m_irq();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = m_mtch[i] & m_ien[i];
    return v;
  endfunction

  function automatic logic [N_CH-1:0] m_pwm();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = m_run[i] & ((m_cnt[i] < m_cmp[i]) ^ m_pol[i]);
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int              due;
    bit              rd;
    logic [11:0]     a;
    logic [31:0]     data;
    logic [N_CH-1:0] irq;
    logic [N_CH-1:0] pwm;
  } exp_t;

  exp_t sbq[$];

  // One bus cycle: drive, predict, queue, then move past the clock edge.
  task automatic step(bit r, bit rq, bit w, logic [11:0] a, logic [31:0] d,
                      bit use_c, logic [31:0] c);
    exp_t e;
    rst_n = r; req = rq; we = w; addr = a; wdata = d;
    e.due  = cyc + 1;
    e.rd   = r && rq && !w;
    e.a    = a;
    e.data = e.rd ? (use_c ? c : m_read(a)) : 32'd0;
    m_edge(r, rq, w, a, d);
    e.irq = m_irq();
    e.pwm = m_pwm();
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [11:0] a, logic [31:0] d); step(1, 1, 1, a, d, 0, 0); endtask
  task automatic rd(logic [11:0] a); step(1, 1, 0, a, 0, 0, 0); endtask
  task automatic rdc(logic [11:0] a, logic [31:0] c); step(1, 1, 0, a, 0, 1, c); endtask
  task automatic idle(int n); for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic rst_cycles(int n); for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0); endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      if (sbq[0].due == cyc) begin
        mon_e = sbq.pop_front();
        chk("rvalid", 64'(rvalid), 64'(mon_e.rd));
        if (mon_e.rd) chk($sformatf("rdata@%03h", mon_e.a), 64'(rdata), 64'(mon_e.data));
        else          chk("rdata_idle", 64'(rdata), 64'd0);
        chk("irq", 64'(irq), 64'(mon_e.irq));
`ifdef TIMER_MC_PWM_EN
        chk("pwm", 64'(pwm), 64'(mon_e.pwm));
`endif
      end else if (sbq[0].due < cyc) begin
        mon_e = sbq.pop_front();
        chk("sbq_stale", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk);
    #1;
    rst_cycles(3);
    // Reset values
    rdc(12'h000, 0); rdc(12'h004, 0); rdc(12'h008, 0); rdc(12'h00C, 0);
    rdc(12'h014, 0); rdc(12'h100, 0);

    // Periodic, PSC=0, CMPR0=3: CNTR0 0,1,2,3,0 and match every 4 cycles
    wr(12'h100, 0); wr(12'h00C, 3); wr(12'h000, 32'h9);
    rdc(12'h008, 0); rdc(12'h008, 1); rdc(12'h008, 2); rdc(12'h008, 3); rdc(12'h008, 0);
    rdc(12'h004, 3);
    idle(6);
    wr(12'h000, 32'h2); wr(12'h004, 1);

    // Single shot, PSC=2, CMPR1=1: match after 6 cycles, then stopped
    wr(12'h100, 2); wr(12'h01C, 1); wr(12'h010, 32'h5);
    idle(5);
    rdc(12'h014, 2); rdc(12'h014, 1); rdc(12'h018, 1);
    idle(6);
    rdc(12'h018, 1); rdc(12'h014, 1);
    wr(12'h014, 1); wr(12'h100, 0);

    // Counter above compare wraps without a match
    wr(12'h00C, 5); wr(12'h008, 32'hFFFF_FFFE); wr(12'h000, 1);
    rdc(12'h008, 32'hFFFF_FFFE); rdc(12'h008, 32'hFFFF_FFFF); rdc(12'h008, 0);
    rdc(12'h004, 2);
    idle(3);
    rdc(12'h008, 5); rdc(12'h004, 3);

    // trg|hlt on a running channel; W1C in the same cycle as a match
    wr(12'h000, 32'h3);
    rdc(12'h004, 1); rdc(12'h008, 0);
    wr(12'h004, 1); wr(12'h00C, 1); wr(12'h000, 1);
    idle(1);
    wr(12'h004, 1);
    rdc(12'h004, 3);

`ifdef TIMER_MC_PWM_EN
    // PWM: CMPR=2 periodic, then with inverted polarity
    wr(12'h000, 32'h2); wr(12'h00C, 2); wr(12'h000, 1);
    idle(6);
    wr(12'h000, 32'h11);
    rdc(12'h000, 32'h10);
    idle(6);
`endif

    // Reset mid-count on both channels
    wr(12'h010, 1); wr(12'h000, 32'h9);
    idle(2);
    rst_cycles(2);
    for (int i = 0; i < N_CH; i++)
      for (int j = 0; j < 4; j++) rdc(12'(i * 16 + j * 4), 0);
    rdc(12'h100, 0); rdc(12'h3F0, 0);

    // Randomised traffic (PSC fixed while channels are idle)
    begin
      logic [31:0] r;
      r = $urandom;
      wr(12'h100, {r[31:16], 14'd0, 2'($urandom_range(0, 3))});
    end
    for (int k = 0; k < 1500; k++) begin
      int op;
      int ch;
      logic [11:0] base;
      logic [31:0] v;
      op = $urandom_range(0, 99);
      ch = $urandom_range(0, N_CH);
      base = 12'(ch * 16);
      v = $urandom;
      if (op < 1) rst_cycles(1);
      else if (op < 30) begin
        case ($urandom_range(0, 5))
          0:       rd(12'h100);
          1:       rd(12'h3F0);
          2:       rd(12'h104);
          default: rd(base + 12'(4 * $urandom_range(0, 3)));
        endcase
      end
      else if (op < 45) idle(1);
      else if (op < 60) begin
        v[0] = ($urandom_range(0, 2) == 0);
        v[1] = ($urandom_range(0, 7) == 0);
        wr(base, v);
      end
      else if (op < 72) wr(base + 12'hC, 32'($urandom_range(0, 6)));
      else if (op < 84) begin
        if ($urandom_range(0, 3) == 0) v = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        else v = 32'($urandom_range(0, 6));
        wr(base + 12'h8, v);
      end
      else wr(base + 12'h4, v);
    end

    idle(2);
    @(negedge clk);
    #2;
    chk("sbq_drain", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
